// File: rtl/interrupt_claim_complete.sv
// Claim/complete gateway: picks the highest-priority eligible source, notifies the core, and tracks one claim.
// Optional claim watchdog is compiled in with `define INTERRUPT_CLAIM_TIMEOUT_EN.
module interrupt_claim_complete #(
    parameter int N_interrupts   = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_interrupts-1:0]    pending_interrupts,
    input  logic [N_interrupts*32-1:0] interrupt_priority_regs,
    input  logic [31:0]              claim_addr,
    input  logic [31:0]              threshold_addr,
    input  logic [31:0]              addr,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     addr_valid,
    output logic [N_interrupts-1:0]    active_interrupt,
    output logic                     interrupt_claimed,
    output logic                     interrupt_service_request,
    output logic                     claim_timeout
);

    localparam int ID_W = $clog2(N_interrupts + 1);

    // Bus handshake: a read or write is a single-cycle strobe (ren/wen) qualified by addr;
    // there is no wait state, rdata is valid combinationally in the strobe cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        NOTIFY  = 2'd1,
        CLAIMED = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [2:0]        threshold;
    logic              cand_valid;
    logic [ID_W-1:0]   cand_id;
    logic [ID_W-1:0]   claimed_id;
    logic              claim_pulse;

    logic              sel_valid;
    logic [2:0]        sel_prio;
    logic [ID_W-1:0]   sel_id;

    logic              claim_hit, thr_hit;
    logic              claim_rd, complete_wr, thr_wr;
    logic              claim_take, complete_ok, timeout_fire;
    logic              prio_upper_unused;

    assign claim_hit   = (addr == claim_addr);
    assign thr_hit     = (addr == threshold_addr);
    assign addr_valid  = claim_hit | thr_hit;
    assign claim_rd    = ren & claim_hit;
    assign complete_wr = wen & claim_hit;
    assign thr_wr      = wen & thr_hit;
    assign claim_take  = claim_rd & (state == NOTIFY);
    assign complete_ok = complete_wr && (wdata == {{(32-ID_W){1'b0}}, claimed_id});

    // Only bits [2:0] of each priority word matter.
    assign prio_upper_unused = ^interrupt_priority_regs;

    // Ascending scan with strict '>' keeps the lowest index on equal priority.
    always_comb begin
        sel_valid = 1'b0;
        sel_prio  = 3'd0;
        sel_id    = '0;
        for (int i = 0; i < N_interrupts; i++) begin
            if (pending_interrupts[i]
                && (interrupt_priority_regs[i*32 +: 3] > threshold)
                && (interrupt_priority_regs[i*32 +: 3] > sel_prio)) begin
                sel_valid = 1'b1;
                sel_prio  = interrupt_priority_regs[i*32 +: 3];
                sel_id    = ID_W'(i + 1);
            end
        end
    end

`ifdef INTERRUPT_CLAIM_TIMEOUT_EN
    logic [31:0] claim_cycles;
    logic        timeout_q;

    assign timeout_fire  = (state == CLAIMED) && !complete_ok
                           && ((claim_cycles + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign claim_timeout = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            claim_cycles <= 32'd0;
            timeout_q    <= 1'b0;
        end else begin
            if (claim_take)
                claim_cycles <= 32'd0;
            else if (state == CLAIMED)
                claim_cycles <= claim_cycles + 32'd1;
            if (thr_wr)
                timeout_q <= 1'b0;
            else if (timeout_fire)
                timeout_q <= 1'b1;
        end
    end
`else
    logic timeout_cfg_unused;

    assign timeout_cfg_unused = (TIMEOUT_CYCLES == 0);
    assign timeout_fire       = 1'b0;
    assign claim_timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cand_valid) state_next = NOTIFY;
            NOTIFY: begin
                if (claim_take)
                    state_next = CLAIMED;
                else if (!cand_valid)
                    state_next = IDLE;
            end
            CLAIMED: if (complete_ok || timeout_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cand_id holds its last winner so a claim racing the candidate's withdrawal still gets that ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            threshold   <= 3'd0;
            cand_valid  <= 1'b0;
            cand_id     <= '0;
            claimed_id  <= '0;
            claim_pulse <= 1'b0;
        end else begin
            cand_valid  <= sel_valid;
            if (sel_valid)
                cand_id <= sel_id;
            if (thr_wr)
                threshold <= wdata[2:0];
            if (claim_take)
                claimed_id <= cand_id;
            claim_pulse <= claim_take;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (claim_rd) begin
            if (state == NOTIFY)
                rdata = {{(32-ID_W){1'b0}}, cand_id};
        end else if (ren && thr_hit) begin
            rdata = {29'd0, threshold};
        end
    end

    always_comb begin
        active_interrupt = '0;
        for (int i = 0; i < N_interrupts; i++)
            active_interrupt[i] = (state == CLAIMED) && (claimed_id == ID_W'(i + 1));
    end

    assign interrupt_claimed         = claim_pulse;
    assign interrupt_service_request = (state == NOTIFY);

endmodule
